stopwatch_input_cond: RTL and testbench

Input-conditioning and timebase stage that sits directly upstream of the stopwatch controller/counter. Two raw push-buttons (reset R, pause/run P) pass through a synchronizer and a per-button debouncer. The block presents R as a clean level and P as a request that is held until the display/FSM scan tick consumes it. It also generates the two single-cycle enables that pace the counter (count tick) and the display/controller FSMs (scan tick) from one system clock.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_debounce.sv | 80 ++++++++
 rtl/stopwatch_input_cond.sv | 69 ++++++
 tb/tb_stopwatch_input_cond.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared debouncer state type and default timing constants for the stopwatch input stage.
package stopwatch_pkg;

  localparam int SYS_CLK_HZ    = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int CNT_DIV_DEF   = SYS_CLK_HZ / 100;
  localparam int SCAN_DIV_DEF  = SYS_CLK_HZ / 1000;

  typedef enum logic [1:0] {
    LO,
    CHK_HI,
    HI,
    CHK_LO
  } db_state_e;

endpackage

// File: rtl/stopwatch_debounce.sv
// Button synchronizer + debouncer: level follows raw DB_CYCLES+3 edges after a stable change.
// STOPWATCH_DB_BYPASS_EN: debouncer removed, level is the second synchronizer flop (2-cycle latency).
module stopwatch_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_DB_BYPASS_EN
  assign level = sync2_q;
`else
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A CHK state falls back as soon as the input reverts, so short glitches never land.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LO: begin
        if (sync2_q) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!sync2_q)              state_d = LO;
        else if (cnt_q == CNT_LAST) state_d = HI;
        else                       cnt_d = cnt_q + 1'b1;
      end
      HI: begin
        if (!sync2_q) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (sync2_q)               state_d = HI;
        else if (cnt_q == CNT_LAST) state_d = LO;
        else                       cnt_d = cnt_q + 1'b1;
      end
      default: state_d = LO;
    endcase
  end

  assign level = (state_q == HI) || (state_q == CHK_LO);
`endif

endmodule

// File: rtl/stopwatch_input_cond.sv
// Debounced R level, held P request/strobe, and free-running count/scan tick enables.
// STOPWATCH_DB_BYPASS_EN (in stopwatch_debounce) swaps debouncing for a bare synchronizer.
module stopwatch_input_cond
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_DIV   = CNT_DIV_DEF,
  parameter int SCAN_DIV  = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_r_raw,
  input  logic btn_p_raw,
  output logic r_level,
  output logic p_req,
  output logic p_pulse,
  output logic cnt_tick,
  output logic scan_tick
);

  localparam int CNT_W  = $clog2(CNT_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic              p_level;
  logic              p_level_q;
  logic              p_req_q, p_req_d;
  logic [CNT_W-1:0]  cnt_div_q, cnt_div_d;
  logic [SCAN_W-1:0] scan_div_q, scan_div_d;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_r_raw),
    .level (r_level)
  );

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_p_raw),
    .level (p_level)
  );

  assign cnt_tick   = (cnt_div_q == CNT_W'(CNT_DIV - 1));
  assign scan_tick  = (scan_div_q == SCAN_W'(SCAN_DIV - 1));
  assign cnt_div_d  = cnt_tick  ? '0 : cnt_div_q + 1'b1;
  assign scan_div_d = scan_tick ? '0 : scan_div_q + 1'b1;

  // The rising-edge strobe is folded into p_req so the request is visible on the same
  // edge the level rises; a press landing on a clearing edge therefore still wins.
  assign p_pulse = p_level & ~p_level_q;
  assign p_req   = p_req_q | p_pulse;
  assign p_req_d = p_req & ~scan_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_level_q  <= 1'b0;
      p_req_q    <= 1'b0;
      cnt_div_q  <= '0;
      scan_div_q <= '0;
    end else begin
      p_level_q  <= p_level;
      p_req_q    <= p_req_d;
      cnt_div_q  <= cnt_div_d;
      scan_div_q <= scan_div_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_input_cond.sv
// Scoreboarded bench for stopwatch_input_cond with DB_CYCLES=4, CNT_DIV=10, SCAN_DIV=4 (plus a SCAN_DIV=32 copy).
module tb_stopwatch_input_cond;

  localparam int DB  = 4;
  localparam int CD  = 10;
  localparam int SD  = 4;
  localparam int SD2 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_r_raw = 1'b0;
  logic btn_p_raw = 1'b0;

  logic r_level, p_req, p_pulse, cnt_tick, scan_tick;
  logic r_level_2, p_req_2, p_pulse_2, cnt_tick_2, scan_tick_2;

  int n_cmp = 0;
  int n_bad = 0;
  int ek;

  typedef struct packed {
    logic r;
    logic preq;
    logic pulse;
    logic cnt;
    logic scan;
  } obs_t;

  obs_t exp_q[$];
  obs_t e;
  obs_t o;

  stopwatch_input_cond #(.DB_CYCLES(DB), .CNT_DIV(CD), .SCAN_DIV(SD)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_r_raw (btn_r_raw),
    .btn_p_raw (btn_p_raw),
    .r_level   (r_level),
    .p_req     (p_req),
    .p_pulse   (p_pulse),
    .cnt_tick  (cnt_tick),
    .scan_tick (scan_tick)
  );

  stopwatch_input_cond #(.DB_CYCLES(DB), .CNT_DIV(CD), .SCAN_DIV(SD2)) u_dut_long (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_r_raw (btn_r_raw),
    .btn_p_raw (btn_p_raw),
    .r_level   (r_level_2),
    .p_req     (p_req_2),
    .p_pulse   (p_pulse_2),
    .cnt_tick  (cnt_tick_2),
    .scan_tick (scan_tick_2)
  );

  always #5 clk = ~clk;

  // Edges since reset release; sampled 1 ns after an edge it equals that edge's number.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ek <= 0;
    else        ek <= ek + 1;
  end

  function automatic obs_t mk_exp(int k, int sd, logic r, logic preq, logic pulse);
    obs_t x;
    x.r     = r;
    x.preq  = preq;
    x.pulse = pulse;
    x.cnt   = ((k % CD) == CD - 1);
    x.scan  = ((k % sd) == sd - 1);
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic r, input logic p);
    rst_n     = 1'b0;
    btn_r_raw = r;
    btn_p_raw = p;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    btn_r_raw = 1'b1;
    btn_p_raw = 1'b1;
    repeat (3) step();
    exp_q.push_back('0);
    exp_q.push_back('0);
    e = exp_q.pop_front();
    o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_main got=%b want=%b", o, e);
    end
    e = exp_q.pop_front();
    o = {r_level_2, p_req_2, p_pulse_2, cnt_tick_2, scan_tick_2};
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_long got=%b want=%b", o, e);
    end
  endtask

  task automatic test_ticks();
    do_reset(1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back(mk_exp(k, SD, 1'b0, 1'b0, 1'b0));
      step();
      e = exp_q.pop_front();
      o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL ticks k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_p_press();
    do_reset(1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back(mk_exp(k, SD, 1'b0, k == 7, k == 7));
      step();
      e = exp_q.pop_front();
      o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL p_press k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_r_glitch();
    do_reset(1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      btn_r_raw = (k <= 20) ? ((((k - 1) / 2) % 2) == 0) : 1'b0;
      exp_q.push_back(mk_exp(k, SD, 1'b0, 1'b0, 1'b0));
      step();
      e = exp_q.pop_front();
      o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL r_glitch k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_r_hold();
    do_reset(1'b1, 1'b0);
    for (int k = 1; k <= 65; k++) begin
      btn_r_raw = (k <= 50);
      exp_q.push_back(mk_exp(k, SD, (k >= 7) && (k <= 56), 1'b0, 1'b0));
      step();
      e = exp_q.pop_front();
      o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL r_hold k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  // Needs the SCAN_DIV=32 copy: with SCAN_DIV=4 a request cannot outlive a full re-press.
  task automatic test_back_to_back();
    do_reset(1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      btn_p_raw = !((k >= 11) && (k <= 17));
      exp_q.push_back(mk_exp(k, SD2, 1'b0, (k >= 7) && (k <= 31), (k == 7) || (k == 24)));
      step();
      e = exp_q.pop_front();
      o = {r_level_2, p_req_2, p_pulse_2, cnt_tick_2, scan_tick_2};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL back_to_back k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      btn_r_raw = (k >= 4);
      exp_q.push_back(mk_exp(k, SD, 1'b0, k == 7, k == 7));
      step();
      e = exp_q.pop_front();
      o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL mid_pre k=%0d got=%b want=%b", k, o, e);
      end
    end
    rst_n = 1'b0;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL mid_async got=%b want=%b", o, e);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(mk_exp(k, SD, k >= 7, k == 7, k == 7));
      step();
      e = exp_q.pop_front();
      o = {r_level, p_req, p_pulse, cnt_tick, scan_tick};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL mid_post k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ticks();
    test_p_press();
    test_r_glitch();
    test_r_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
